// File: rtl/counter.sv
// 16-bit up/down counter with a level-sampled count enable.
// The count register drives Q directly. An active-high reset clears it asynchronously.
module counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_p,
    input  logic        UHDL,
    output logic [15:0] Q
);

    logic [15:0] count;

    // Reset has priority. Otherwise the count takes one step in the direction UHDL
    // selects on every enabled edge, and it wraps modulo 2^16.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'h0000;
        end else if (inc_p) begin
            if (UHDL) begin
                count <= count + 16'd1;
            end else begin
                count <= count - 16'd1;
            end
        end
    end

    assign Q = count;

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for counter.
// The bench drives inputs on the falling edge and checks Q #1 after the rising edge.
module tb_counter;

    logic        clk;
    logic        reset;
    logic        inc_p;
    logic        UHDL;
    logic [15:0] Q;

    int check_count;
    int error_count;

    counter dut (
        .clk   (clk),
        .reset (reset),
        .inc_p (inc_p),
        .UHDL  (UHDL),
        .Q     (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of stimulus on the falling edge and waits past the next rising edge.
    task automatic applyStimulus(input logic inc, input logic dir);
        @(negedge clk);
        inc_p = inc;
        UHDL  = dir;
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        reset = 1'b1;
        inc_p = 1'b0;
        UHDL  = 1'b0;

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("reset_async", Q, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset_hold", Q, 16'h0000);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("up_step", Q, 16'(i));
            applyStimulus(1'b0, 1'b1);
            checkOutput("up_idle", Q, 16'(i));
        end

        for (int i = 4; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("down_step", Q, 16'(i));
            applyStimulus(1'b0, 1'b0);
            checkOutput("down_idle", Q, 16'(i));
        end

        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap_down", Q, 16'hFFFF);
        applyStimulus(1'b1, 1'b1);
        checkOutput("wrap_up", Q, 16'h0000);

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("held_step", Q, 16'(i));
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("held_off_dn", Q, 16'h0003);
        applyStimulus(1'b0, 1'b1);
        checkOutput("held_off_up", Q, 16'h0003);
        applyStimulus(1'b0, 1'b0);
        checkOutput("held_off_dn2", Q, 16'h0003);

        // Reset is raised partway through the low phase, with enable high.
        @(negedge clk);
        inc_p = 1'b1;
        UHDL  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_async", Q, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("mid_reset_nostep", Q, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        inc_p = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("post_reset_step", Q, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 The block SHALL have no parameters; the count width is fixed at 16 bits.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; clears the count.
REQ-004 inc_p  input  1  count-enable pulse; active-high; one count step per rising clk edge while high.
REQ-005 UHDL  input  1  direction select; 1 = count up, 0 = count down.
REQ-006 Q  output  16  current count value, unsigned, driven directly from the count register.

Function
REQ-007 The block SHALL hold a single 16-bit count register, and Q SHALL equal that register at all times, with no combinational path from any input to Q.
REQ-008 On a rising clk edge with reset low, inc_p high and UHDL high, the count SHALL become count + 1 modulo 2^16.
REQ-009 On a rising clk edge with reset low, inc_p high and UHDL low, the count SHALL become count - 1 modulo 2^16.
REQ-010 On a rising clk edge with reset low and inc_p low, the count SHALL hold its value regardless of UHDL.
REQ-011 Latency SHALL be one edge: the new value SHALL appear on Q after the same rising edge that samples inc_p high.
REQ-012 inc_p SHALL be level-sampled, not edge-detected: holding it high for N consecutive rising edges SHALL step the count N times.
REQ-013 The up-count wrap SHALL be 16'hFFFF + 1 -> 16'h0000, with no saturation and no flag.
REQ-014 The down-count wrap SHALL be 16'h0000 - 1 -> 16'hFFFF, with no saturation and no flag.
REQ-015 UHDL SHALL be sampled only on the edge where inc_p is high, and a direction change between steps SHALL take effect on the next enabled edge.
REQ-016 The inputs inc_p and UHDL SHALL be treated as synchronous to clk, with no internal synchronizers; the source must meet setup/hold.

Reset
REQ-017 While reset is high, the count SHALL be forced to 16'h0000 immediately, without waiting for a clk edge, and Q SHALL read 16'h0000.
REQ-018 Reset SHALL take priority over inc_p and UHDL, and the count SHALL NOT step on any clk edge during which reset is high.
REQ-019 After reset deasserts, the first possible step SHALL occur at the first rising clk edge that samples reset low and inc_p high.
REQ-020 Reset asserted mid-sequence, for example between up-steps, SHALL discard the accumulated count and return Q to 16'h0000.
REQ-021 The power-up value of the count before the first reset is not specified, and benches SHALL apply reset before checking Q.

Verification
REQ-022 The bench SHALL cover these directed scenarios, driving stimulus on the falling clk edge and checking Q after the rising edge:
- Reset: pulse reset high for one cycle -> Q = 0x0000 at once, and Q holds 0x0000 with inc_p low.
- Up-count: 5 repeats of {inc_p=1, UHDL=1 for one cycle; then inc_p=0 for one cycle} -> Q goes 1,1,2,2,3,3,4,4,5,5.
- Down-count: continuing from Q=5, 5 repeats of {inc_p=1, UHDL=0 for one cycle; then inc_p=0 for one cycle} -> Q goes 4,4,3,3,2,2,1,1,0,0.
- Wrap: from 0x0000 with one down-step -> Q = 0xFFFF, then one up-step -> Q = 0x0000.
- Held enable: inc_p=1, UHDL=1 held for 3 edges from 0 -> Q = 3; then inc_p=0 with UHDL toggling -> Q stays 3.
- Async reset mid-run: from Q=3, assert reset between clk edges -> Q = 0x0000 before the next rising edge, and inc_p high during reset causes no step.
